// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_sub_pkg;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} sub_state_t;

   // Bit counter width; a 1-bit operand still needs a 1-bit counter.
   function automatic int unsigned cnt_width(input int unsigned w);
      return (w > 1) ? 32'($clog2(w)) : 32'd1;
   endfunction

endpackage

// File: rtl/full_subtractor.sv
// Full subtractor built from two half subtractors and an OR on the borrows.
module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic bi,
   output logic d,
   output logic bo
);

   logic d1, b1, b2;

   half_subtractor u_hs0 (.x(x),  .y(y),  .d(d1), .bo(b1));
   half_subtractor u_hs1 (.x(d1), .y(bi), .d(d),  .bo(b2));

   assign bo = b1 | b2;

endmodule

// File: rtl/half_subtractor.sv
// Half subtractor: d = x - y, bo = borrow out.
module half_subtractor (
   input  logic x,
   input  logic y,
   output logic d,
   output logic bo
);

   assign d  = x ^ y;
   assign bo = ~x & y;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b - bin, one bit per clock, LSB first,
// behind a start/ready/done handshake.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             done
);

   localparam int unsigned CW = cnt_width(WIDTH);

   sub_state_t       state, state_d;
   logic [WIDTH-1:0] a_sh, b_sh, res;
   logic [CW-1:0]    cnt;
   logic             br;
   logic             d_bit, bo_bit;
   logic             last_c;
   logic [WIDTH-1:0] res_next_c;

   full_subtractor u_fs (
      .x (a_sh[0]),
      .y (b_sh[0]),
      .bi(br),
      .d (d_bit),
      .bo(bo_bit)
   );

   assign last_c     = (cnt == CW'(WIDTH - 1));
   // New bit enters at the MSB so the LSB-first stream lands in place after WIDTH shifts.
   assign res_next_c = (res >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));

   // Next-state logic
   always_comb begin
      state_d = state;
      case (state)
         S_IDLE:  if (start) state_d = S_BUSY;
         S_BUSY:  if (last_c) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State register and registered handshake outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         ready <= 1'b1;
         done  <= 1'b0;
      end else begin
         state <= state_d;
         ready <= (state_d == S_IDLE);
         done  <= (state_d == S_DONE);
      end
   end

   // Serial datapath: operand shifters, borrow flop, counter, result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh <= '0;
         b_sh <= '0;
         res  <= '0;
         cnt  <= '0;
         br   <= 1'b0;
         diff <= '0;
         bout <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  a_sh <= a;
                  b_sh <= b;
                  br   <= bin;
                  cnt  <= '0;
               end
            end
            S_BUSY: begin
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               res  <= res_next_c;
               br   <= bo_bit;
               cnt  <= cnt + CW'(1);
               if (last_c) begin
                  diff <= res_next_c;
                  bout <= bo_bit;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
